pipeline_hazard_ctrl: RTL and testbench

//  Central stall/flush scheduler for the 5-stage MIPS pipeline. Merges three hazard sources:

---
 rtl/hazard_pkg.sv | 35 +++
 rtl/hazard_loaduse_cmp.sv | 23 ++
 rtl/pipeline_hazard_ctrl.sv | 134 +++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Optional statistics counters are enabled with HAZARD_STATS_EN.
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        MEM_WAIT   = 2'd1,
        FLUSH_PEND = 2'd2
    } hz_state_t;

    localparam logic [5:0] OP_RTYPE   = 6'b000000;
    localparam logic [5:0] OP_SW      = 6'b101011;
    localparam logic [1:0] S_DATA_MEM = 2'b01;

    typedef struct packed {
        logic pc_hold;
        logic if_id_hold;
        logic if_id_flush;
        logic id_exe_hold;
        logic id_exe_flush;
        logic exe_mem_hold;
        logic mem_wb_flush;
    } hz_ctrl_t;

    localparam hz_ctrl_t CTRL_NONE    = '{default: 1'b0};
    localparam hz_ctrl_t CTRL_RESET   = '{if_id_flush: 1'b1, id_exe_flush: 1'b1,
                                          mem_wb_flush: 1'b1, default: 1'b0};
    localparam hz_ctrl_t CTRL_MEMWAIT = '{pc_hold: 1'b1, if_id_hold: 1'b1, id_exe_hold: 1'b1,
                                          exe_mem_hold: 1'b1, mem_wb_flush: 1'b1, default: 1'b0};
    localparam hz_ctrl_t CTRL_BRANCH  = '{if_id_flush: 1'b1, id_exe_flush: 1'b1, default: 1'b0};
    localparam hz_ctrl_t CTRL_LOADUSE = '{pc_hold: 1'b1, if_id_hold: 1'b1, id_exe_flush: 1'b1,
                                          default: 1'b0};
    localparam hz_ctrl_t CTRL_ABORT   = '{mem_wb_flush: 1'b1, default: 1'b0};

endpackage

// File: rtl/hazard_loaduse_cmp.sv
// Combinational load-use detector: ID-stage sources against an in-flight EXE load.
module hazard_loaduse_cmp
    import hazard_pkg::*;
(
    input  logic [4:0] rs,
    input  logic [4:0] rt,
    input  logic [5:0] op,
    input  logic [4:0] exe_num_write,
    input  logic       exe_reg_write,
    input  logic [1:0] exe_s_data_write,
    output logic       hit
);

    logic exe_is_load;
    logic rt_is_source;

    // rt is only a source for R-type ALU ops and stores; I-type ops write it.
    assign exe_is_load  = exe_reg_write && (exe_s_data_write == S_DATA_MEM) && (exe_num_write != 5'd0);
    assign rt_is_source = (op == OP_RTYPE) || (op == OP_SW);
    assign hit = exe_is_load &&
                 ((exe_num_write == rs) || ((exe_num_write == rt) && rt_is_source));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush scheduler for the 5-stage pipeline: memory wait > branch flush > load-use.
// Define HAZARD_STATS_EN to add stall_cycles / flush_events counters.
module pipeline_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [5:0]  op,
    input  logic [4:0]  EXE_num_write,
    input  logic        EXE_reg_write,
    input  logic [1:0]  EXE_s_data_write,
    input  logic        EXE_branch_taken,
    input  logic        MEM_req,
    input  logic        MEM_ready,
    output logic        pc_hold,
    output logic        IF_ID_hold,
    output logic        IF_ID_flush,
    output logic        ID_EXE_hold,
    output logic        ID_EXE_flush,
    output logic        EXE_MEM_hold,
    output logic        MEM_WB_flush,
`ifdef HAZARD_STATS_EN
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_events,
`endif
    output logic        mem_timeout
);

    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(MEM_TIMEOUT);

    hz_state_t        state;
    logic [CNT_W-1:0] wait_cnt;
    logic             branch_pend;
    logic             lu_hit;
    logic             mem_stall;
    logic             wait_tmo;
    logic             wait_done;
    hz_ctrl_t         ctrl;

    hazard_loaduse_cmp u_lu (
        .rs               (rs),
        .rt               (rt),
        .op               (op),
        .exe_num_write    (EXE_num_write),
        .exe_reg_write    (EXE_reg_write),
        .exe_s_data_write (EXE_s_data_write),
        .hit              (lu_hit)
    );

    assign mem_stall = MEM_req && !MEM_ready;
    // A ready in the final cycle wins over the abort.
    assign wait_tmo  = (state == MEM_WAIT) && mem_stall && (wait_cnt == CNT_LIMIT);
    assign wait_done = !mem_stall || wait_tmo;

    always_comb begin
        ctrl = CTRL_NONE;
        if (rst) begin
            ctrl = CTRL_RESET;
        end else begin
            unique case (state)
                RUN: begin
                    if (mem_stall)             ctrl = CTRL_MEMWAIT;
                    else if (EXE_branch_taken) ctrl = CTRL_BRANCH;
                    else if (lu_hit)           ctrl = CTRL_LOADUSE;
                end
                MEM_WAIT: begin
                    if (wait_tmo)        ctrl = CTRL_ABORT;
                    else if (!wait_done) ctrl = CTRL_MEMWAIT;
                end
                FLUSH_PEND: ctrl = CTRL_BRANCH;
                default:    ctrl = CTRL_NONE;
            endcase
        end
    end

    assign pc_hold      = ctrl.pc_hold;
    assign IF_ID_hold   = ctrl.if_id_hold;
    assign IF_ID_flush  = ctrl.if_id_flush;
    assign ID_EXE_hold  = ctrl.id_exe_hold;
    assign ID_EXE_flush = ctrl.id_exe_flush;
    assign EXE_MEM_hold = ctrl.exe_mem_hold;
    assign MEM_WB_flush = ctrl.mem_wb_flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= RUN;
            wait_cnt    <= '0;
            branch_pend <= 1'b0;
            mem_timeout <= 1'b0;
        end else begin
            unique case (state)
                RUN: begin
                    if (mem_stall) begin
                        state       <= MEM_WAIT;
                        wait_cnt    <= CNT_W'(1);
                        branch_pend <= EXE_branch_taken;
                    end
                end
                MEM_WAIT: begin
                    if (wait_done) begin
                        state    <= branch_pend ? FLUSH_PEND : RUN;
                        wait_cnt <= '0;
                        if (wait_tmo) mem_timeout <= 1'b1;
                    end else if (wait_cnt != '1) begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                FLUSH_PEND: begin
                    branch_pend <= 1'b0;
                    state       <= RUN;
                end
                default: state <= RUN;
            endcase
        end
    end

`ifdef HAZARD_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles <= '0;
            flush_events <= '0;
        end else begin
            if (pc_hold)     stall_cycles <= stall_cycles + 32'd1;
            if (IF_ID_flush) flush_events <= flush_events + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed vector table, timeout/reset sequences, random vs model.
module tb_pipeline_hazard_ctrl;

    logic clk = 1'b0;
    logic rst;
    logic [4:0] rs, rt, EXE_num_write;
    logic [5:0] op;
    logic EXE_reg_write, EXE_branch_taken, MEM_req, MEM_ready;
    logic [1:0] EXE_s_data_write;
    logic pc_hold, IF_ID_hold, IF_ID_flush, ID_EXE_hold, ID_EXE_flush, EXE_MEM_hold, MEM_WB_flush;
    logic mem_timeout;
`ifdef HAZARD_STATS_EN
    logic [31:0] stall_cycles, flush_events;
`endif

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.MEM_TIMEOUT(64), .CNT_W(7)) dut (
        .clk(clk), .rst(rst), .rs(rs), .rt(rt), .op(op),
        .EXE_num_write(EXE_num_write), .EXE_reg_write(EXE_reg_write),
        .EXE_s_data_write(EXE_s_data_write), .EXE_branch_taken(EXE_branch_taken),
        .MEM_req(MEM_req), .MEM_ready(MEM_ready),
        .pc_hold(pc_hold), .IF_ID_hold(IF_ID_hold), .IF_ID_flush(IF_ID_flush),
        .ID_EXE_hold(ID_EXE_hold), .ID_EXE_flush(ID_EXE_flush),
        .EXE_MEM_hold(EXE_MEM_hold), .MEM_WB_flush(MEM_WB_flush),
`ifdef HAZARD_STATS_EN
        .stall_cycles(stall_cycles), .flush_events(flush_events),
`endif
        .mem_timeout(mem_timeout)
    );

    // Output bit order: pc_hold IF_ID_hold IF_ID_flush ID_EXE_hold ID_EXE_flush EXE_MEM_hold MEM_WB_flush mem_timeout
    localparam logic [7:0] O_IDLE = 8'h00, O_RST = 8'h2A, O_LU = 8'hC8, O_WAIT = 8'hD6,
                           O_BR = 8'h28, O_ABORT = 8'h02, O_STICKY = 8'h01;

    typedef struct {
        logic       rst;
        logic [4:0] rs, rt;
        logic [5:0] op;
        logic [4:0] num;
        logic       rw;
        logic [1:0] sdw;
        logic       br, req, rdy;
        logic [7:0] exp;
    } vec_t;

    int total = 0;
    int bad   = 0;

    // Reference model: where the pipeline is, how long memory has been waited on,
    // whether a taken branch is owed a flush, and the sticky error.
    int  m_mode = 0;   // 0 running, 1 waiting on memory, 2 owed branch flush
    int  m_waited = 0;
    bit  m_pend = 0, m_sticky = 0;
    longint m_stalls = 0, m_flushes = 0;

    function automatic vec_t mk(logic r, logic [4:0] s, logic [4:0] t, logic [5:0] o,
                                logic [4:0] n, logic w, logic [1:0] d,
                                logic b, logic q, logic y, logic [7:0] e);
        vec_t v;
        v.rst = r; v.rs = s; v.rt = t; v.op = o; v.num = n; v.rw = w; v.sdw = d;
        v.br = b; v.req = q; v.rdy = y; v.exp = e;
        return v;
    endfunction

    function automatic bit model_loaduse(vec_t v);
        bit reads_rt;
        if (!(v.rw && v.sdw == 2'b01) || v.num == 5'd0) return 1'b0;
        reads_rt = (v.op == 6'd0) || (v.op == 6'b101011);
        return (v.num == v.rs) || (reads_rt && v.num == v.rt);
    endfunction

    task automatic cycle(input vec_t v, input bit use_tbl, input string name);
        logic [7:0] mexp, exp, act;
        int n_mode, n_waited;
        bit n_pend, n_sticky;
        rst = v.rst; rs = v.rs; rt = v.rt; op = v.op; EXE_num_write = v.num;
        EXE_reg_write = v.rw; EXE_s_data_write = v.sdw; EXE_branch_taken = v.br;
        MEM_req = v.req; MEM_ready = v.rdy;
        n_mode = m_mode; n_waited = m_waited; n_pend = m_pend; n_sticky = m_sticky;
        mexp = O_IDLE;
        if (v.rst) mexp = O_RST;
        else if (m_mode == 0) begin
            if (v.req && !v.rdy) begin
                mexp = O_WAIT; n_mode = 1; n_waited = 1; n_pend = v.br;
            end else if (v.br) mexp = O_BR;
            else if (model_loaduse(v)) mexp = O_LU;
        end else if (m_mode == 1) begin
            if (v.rdy || !v.req) n_mode = m_pend ? 2 : 0;
            else if (m_waited == 64) begin
                mexp = O_ABORT; n_sticky = 1; n_mode = m_pend ? 2 : 0;
            end else begin
                mexp = O_WAIT; n_waited = m_waited + 1;
            end
        end else begin
            mexp = O_BR; n_mode = 0; n_pend = 0;
        end
        if (!v.rst) mexp[0] = m_sticky;
        @(negedge clk);
        exp = use_tbl ? v.exp : mexp;
        act = {pc_hold, IF_ID_hold, IF_ID_flush, ID_EXE_hold, ID_EXE_flush,
               EXE_MEM_hold, MEM_WB_flush, mem_timeout};
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
        @(posedge clk);
        if (v.rst) begin
            m_mode = 0; m_waited = 0; m_pend = 0; m_sticky = 0; m_stalls = 0; m_flushes = 0;
        end else begin
            m_stalls  += longint'(mexp[7]);
            m_flushes += longint'(mexp[5]);
            m_mode = n_mode; m_waited = n_waited; m_pend = n_pend; m_sticky = n_sticky;
        end
        #1;
    endtask

    vec_t tbl[28];

    initial begin
        vec_t v;
        //            rst rs  rt  op       num rw sdw   br req rdy exp
        tbl[0]  = mk(1, 0,  0,  6'd0,    0,  0, 2'b00, 0, 0, 0, O_RST);
        tbl[1]  = mk(0, 0,  0,  6'd0,    0,  0, 2'b00, 0, 0, 0, O_IDLE);
        tbl[2]  = mk(0, 5,  7,  6'd0,    5,  1, 2'b01, 0, 0, 0, O_LU);    // lw $5; add $6,$5,$7
        tbl[3]  = mk(0, 6,  7,  6'd0,    5,  0, 2'b00, 0, 0, 0, O_IDLE);  // stall lasts one cycle
        tbl[4]  = mk(0, 0,  3,  6'd0,    0,  1, 2'b01, 0, 0, 0, O_IDLE);  // load to $0 never stalls
        tbl[5]  = mk(0, 1,  5,  6'h08,   5,  1, 2'b01, 0, 0, 0, O_IDLE);  // addi writes rt
        tbl[6]  = mk(0, 1,  5,  6'h2B,   5,  1, 2'b01, 0, 0, 0, O_LU);    // sw reads rt
        tbl[7]  = mk(0, 1,  5,  6'd0,    5,  1, 2'b01, 0, 0, 0, O_LU);    // R-type reads rt
        tbl[8]  = mk(0, 5,  5,  6'd0,    5,  0, 2'b01, 0, 0, 0, O_IDLE);  // no register write
        tbl[9]  = mk(0, 5,  5,  6'd0,    5,  1, 2'b00, 0, 0, 0, O_IDLE);  // ALU result, not load
        tbl[10] = mk(0, 5,  7,  6'd0,    5,  1, 2'b01, 1, 0, 0, O_BR);    // branch beats load-use
        tbl[11] = mk(0, 0,  0,  6'd0,    0,  0, 2'b00, 0, 1, 0, O_WAIT);  // 3-cycle memory wait
        tbl[12] = mk(0, 0,  0,  6'd0,    0,  0, 2'b00, 0, 1, 0, O_WAIT);
        tbl[13] = mk(0, 0,  0,  6'd0,    0,  0, 2'b00, 0, 1, 0, O_WAIT);
        tbl[14] = mk(0, 0,  0,  6'd0,    0,  0, 2'b00, 0, 1, 1, O_IDLE);
        tbl[15] = mk(0, 0,  0,  6'd0,    0,  0, 2'b00, 0, 0, 0, O_IDLE);
        tbl[16] = mk(0, 0,  0,  6'd0,    0,  0, 2'b00, 1, 1, 0, O_WAIT);  // branch at wait start
        tbl[17] = mk(0, 0,  0,  6'd0,    0,  0, 2'b00, 1, 1, 0, O_WAIT);
        tbl[18] = mk(0, 0,  0,  6'd0,    0,  0, 2'b00, 1, 1, 1, O_IDLE);
        tbl[19] = mk(0, 0,  0,  6'd0,    0,  0, 2'b00, 0, 0, 0, O_BR);    // deferred flush
        tbl[20] = mk(0, 0,  0,  6'd0,    0,  0, 2'b00, 0, 0, 0, O_IDLE);
        tbl[21] = mk(0, 0,  0,  6'd0,    0,  0, 2'b00, 0, 1, 0, O_WAIT);
        tbl[22] = mk(0, 0,  0,  6'd0,    0,  0, 2'b00, 0, 0, 0, O_IDLE);  // req dropped = ready
        tbl[23] = mk(0, 0,  0,  6'd0,    0,  0, 2'b00, 0, 0, 0, O_IDLE);
        tbl[24] = mk(0, 0,  0,  6'd0,    0,  0, 2'b00, 1, 1, 0, O_WAIT);  // reset mid-wait
        tbl[25] = mk(0, 0,  0,  6'd0,    0,  0, 2'b00, 1, 1, 0, O_WAIT);
        tbl[26] = mk(1, 0,  0,  6'd0,    0,  0, 2'b00, 1, 1, 0, O_RST);
        tbl[27] = mk(0, 0,  0,  6'd0,    0,  0, 2'b00, 0, 0, 0, O_IDLE);  // pending branch discarded

        for (int i = 0; i < 28; i++) cycle(tbl[i], 1'b1, $sformatf("vec%0d", i));

        // Memory never answers: 64 hold cycles, abort cycle, then sticky error.
        for (int i = 0; i < 65; i++) begin
            v = mk(0, 0, 0, 6'd0, 0, 0, 2'b00, 0, 1, 0, (i < 64) ? O_WAIT : O_ABORT);
            cycle(v, 1'b1, $sformatf("timeout%0d", i));
        end
        v = mk(0, 0, 0, 6'd0, 0, 0, 2'b00, 0, 0, 0, O_STICKY);
        cycle(v, 1'b1, "sticky0");
        v = mk(0, 5, 0, 6'd0, 5, 1, 2'b01, 0, 0, 0, O_LU | O_STICKY);
        cycle(v, 1'b1, "sticky_lu");
        v = mk(1, 0, 0, 6'd0, 0, 0, 2'b00, 0, 0, 0, O_RST);
        cycle(v, 1'b1, "sticky_rst");
        v = mk(0, 0, 0, 6'd0, 0, 0, 2'b00, 0, 0, 0, O_IDLE);
        cycle(v, 1'b1, "after_rst");

        // Random traffic against the model; long memory stalls are made likely in bursts.
        for (int i = 0; i < 3000; i++) begin
            int k;
            v.rst = ($urandom_range(0, 299) == 0);
            v.rs  = 5'($urandom_range(0, 4));
            v.rt  = 5'($urandom_range(0, 4));
            k = $urandom_range(0, 3);
            v.op  = (k == 0) ? 6'd0 : (k == 1) ? 6'h2B : (k == 2) ? 6'h08 : 6'($urandom);
            v.num = 5'($urandom_range(0, 4));
            v.rw  = 1'($urandom_range(0, 3) != 0);
            v.sdw = 2'($urandom);
            v.br  = ($urandom_range(0, 5) == 0);
            v.req = ((i / 200) % 3 == 2) ? 1'b1 : 1'($urandom_range(0, 2) == 0);
            v.rdy = ((i / 200) % 3 == 2) ? 1'b0 : 1'($urandom_range(0, 2) == 0);
            v.exp = 8'h00;
            cycle(v, 1'b0, "random");
        end

`ifdef HAZARD_STATS_EN
        total++;
        if (stall_cycles !== 32'(m_stalls)) begin
            bad++;
            $display("FAIL stall_cycles: got %0d expected %0d", stall_cycles, m_stalls);
        end
        total++;
        if (flush_events !== 32'(m_flushes)) begin
            bad++;
            $display("FAIL flush_events: got %0d expected %0d", flush_events, m_flushes);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
